// File: rtl/prio_arbiter_pkg.sv
// ============================================================================
// prio_arbiter_pkg : shared state encodings, policy constants, clog2 helper
// Revision 1.0
// ============================================================================
`default_nettype none

package prio_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// ============================================================================
// prio_pick : combinational winner search, fixed (highest index) or rotated
// Revision 1.0
// ============================================================================
`default_nettype none

module prio_pick
  import prio_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo_all;
  logic [W-1:0] w_lo_up;
  logic         w_hit_up;

  // Descending scans leave the lowest matching index in the lo_* terms.
  always_comb begin
    w_hi     = '0;
    w_lo_all = '0;
    w_lo_up  = '0;
    w_hit_up = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_hi = W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_all = W'(i);
        if (i >= int'(ptr)) begin
          w_lo_up  = W'(i);
          w_hit_up = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any = |req;
    if (!mode) begin
      idx = w_hi;
    end else begin
      idx = w_hit_up ? w_lo_up : w_lo_all;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prio_arbiter.sv
// ============================================================================
// prio_arbiter : registered N-way arbiter, fixed-priority or round-robin,
//                grant held until acknowledged
// Revision 1.0
// ============================================================================
`default_nettype none

module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = PRIO_FIXED,
  parameter int W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] Y,
  output logic [N-1:0] gnt,
  output logic         V
);

  localparam logic [W-1:0] c_LAST = W'(N - 1);
  localparam logic [N-1:0] c_ONE  = N'(1);
  localparam logic         c_RR   = (MODE == PRIO_RR);

  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_eval;
  logic [W-1:0] r_y;
  logic [W-1:0] w_y_nxt;
  logic [N-1:0] r_gnt;
  logic [N-1:0] w_gnt_nxt;
  logic         r_v;
  logic         w_v_nxt;
  logic         w_done;
  logic [W-1:0] w_pick_idx;
  logic         w_pick_any;

  assign w_done = (r_state == ST_GRANT) && ack;

  // The pointer advances on completion, and the back-to-back pick already sees it.
  always_comb begin
    w_ptr_eval = r_ptr;
    if (c_RR && w_done) begin
      w_ptr_eval = (r_y == c_LAST) ? '0 : r_y + W'(1);
    end
  end

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req  (req),
    .ptr  (w_ptr_eval),
    .mode (c_RR),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_y     <= '0;
      r_gnt   <= '0;
      r_v     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_eval;
      r_y     <= w_y_nxt;
      r_gnt   <= w_gnt_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_any) w_state_nxt = ST_GRANT;
      ST_GRANT: if (ack && !w_pick_any) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_y_nxt   = r_y;
    w_gnt_nxt = r_gnt;
    w_v_nxt   = r_v;
    if ((r_state == ST_IDLE) || w_done) begin
      if (w_pick_any) begin
        w_y_nxt   = w_pick_idx;
        w_gnt_nxt = c_ONE << w_pick_idx;
        w_v_nxt   = 1'b1;
      end else begin
        w_gnt_nxt = '0;
        w_v_nxt   = 1'b0;
      end
    end
  end

  assign Y   = r_y;
  assign gnt = r_gnt;
  assign V   = r_v;

endmodule

`default_nettype wire

// File: tb/tb_prio_arbiter.sv
// ============================================================================
// tb_prio_arbiter : directed tables plus random traffic against a spec model,
//                   one fixed-priority and one round-robin instance
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prio_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  typedef struct {
    logic [N-1:0] req;
    int           y;
    logic         v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req0, req1;
  logic         ack0, ack1;
  logic [W-1:0] y0, y1;
  logic [N-1:0] gnt0, gnt1;
  logic         v0, v1;

  int checks = 0;
  int errors = 0;

  int m_v   [2];
  int m_y   [2];
  int m_ptr [2];

  always #5 clk = ~clk;

  prio_arbiter #(.N(N), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req0), .ack(ack0), .Y(y0), .gnt(gnt0), .V(v0)
  );

  prio_arbiter #(.N(N), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1), .Y(y1), .gnt(gnt1), .V(v1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Fixed: highest set bit via log2; round-robin: lowest set bit of req rotated by ptr.
  function automatic int win(input logic [N-1:0] r, input int ptr, input int mode);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   low;
    if (mode == 0) return $clog2(int'(r) + 1) - 1;
    dbl = {r, r};
    rot = N'(dbl >> ptr);
    low = rot & (~rot + 1'b1);
    return ($clog2(int'(low)) + ptr) % N;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 0; m_y[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic model_edge(input int m, input logic [N-1:0] r, input logic a);
    if (m_v[m] == 0) begin
      if (r != 0) begin
        m_y[m] = win(r, m_ptr[m], m);
        m_v[m] = 1;
      end
    end else if (a) begin
      if (m == 1) m_ptr[m] = (m_y[m] + 1) % N;
      if (r != 0) m_y[m] = win(r, m_ptr[m], m);
      else        m_v[m] = 0;
    end
  endtask

  task automatic compare_all();
    chk("fix_V",   32'(v0),   32'(m_v[0]));
    chk("fix_Y",   32'(y0),   32'(m_y[0]));
    chk("fix_gnt", 32'(gnt0), (m_v[0] != 0) ? (32'd1 << m_y[0]) : 32'd0);
    chk("rr_V",    32'(v1),   32'(m_v[1]));
    chk("rr_Y",    32'(y1),   32'(m_y[1]));
    chk("rr_gnt",  32'(gnt1), (m_v[1] != 0) ? (32'd1 << m_y[1]) : 32'd0);
  endtask

  task automatic step();
    model_edge(0, req0, ack0);
    model_edge(1, req1, ack1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    req0 = '0; req1 = '0; ack0 = 1'b0; ack1 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_V",   32'(v0),   0);
    chk("rst_gnt", 32'(gnt0), 0);
    chk("rst_Y",   32'(y0),   0);
    chk("rst_rrV", 32'(v1),   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl [16];
  int   rr_seq [5];

  initial begin
    tbl[0]  = '{4'h0, 0, 1'b0}; tbl[1]  = '{4'h1, 0, 1'b1};
    tbl[2]  = '{4'h2, 1, 1'b1}; tbl[3]  = '{4'h3, 1, 1'b1};
    tbl[4]  = '{4'h4, 2, 1'b1}; tbl[5]  = '{4'h5, 2, 1'b1};
    tbl[6]  = '{4'h6, 2, 1'b1}; tbl[7]  = '{4'h7, 2, 1'b1};
    tbl[8]  = '{4'h8, 3, 1'b1}; tbl[9]  = '{4'h9, 3, 1'b1};
    tbl[10] = '{4'hA, 3, 1'b1}; tbl[11] = '{4'hB, 3, 1'b1};
    tbl[12] = '{4'hC, 3, 1'b1}; tbl[13] = '{4'hD, 3, 1'b1};
    tbl[14] = '{4'hE, 3, 1'b1}; tbl[15] = '{4'hF, 3, 1'b1};
    rr_seq  = '{1, 2, 3, 0, 1};

    do_reset();

    // Fixed priority: grant, hold under changing req, then back-to-back.
    req0 = 4'b0110;
    step();
    chk("A_first_Y", 32'(y0), 2);
    chk("A_first_gnt", 32'(gnt0), 4);
    chk("A_first_V", 32'(v0), 1);
    req0 = 4'b1000;
    repeat (3) begin
      step();
      chk("A_hold_Y", 32'(y0), 2);
      chk("A_hold_V", 32'(v0), 1);
    end
    ack0 = 1'b1;
    step();
    chk("A_b2b_Y", 32'(y0), 3);
    chk("A_b2b_gnt", 32'(gnt0), 8);
    req0 = '0;
    step();
    ack0 = 1'b0;

    // Round-robin sweep with continuous ack.
    req1 = 4'b1111;
    step();
    chk("B_first_Y", 32'(y1), 0);
    ack1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("B_sweep_Y", 32'(y1), 32'(rr_seq[i]));
      chk("B_sweep_V", 32'(v1), 1);
    end
    step();
    chk("B_pre_sparse_Y", 32'(y1), 2);
    req1 = 4'b0011;
    step();
    chk("B_wrap_Y", 32'(y1), 0);
    step();
    chk("B_next_Y", 32'(y1), 1);
    req1 = '0;
    step();
    chk("B_release_V", 32'(v1), 0);
    chk("B_release_gnt", 32'(gnt1), 0);
    chk("B_release_Y", 32'(y1), 1);
    repeat (2) begin
      step();
      chk("B_idle_ack_V", 32'(v1), 0);
      chk("B_idle_ack_Y", 32'(y1), 1);
    end
    ack1 = 1'b0;

    // Exhaustive fixed-priority table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req0 = tbl[i].req;
      ack0 = 1'b0;
      step();
      chk("C_V", 32'(v0), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("C_Y", 32'(y0), 32'(tbl[i].y));
        chk("C_gnt", 32'(gnt0), 32'd1 << tbl[i].y);
        ack0 = 1'b1;
        req0 = '0;
        step();
        ack0 = 1'b0;
      end else begin
        chk("C_gnt0", 32'(gnt0), 0);
      end
    end

    // Asynchronous reset between edges while a grant is outstanding.
    req0 = 4'b1000;
    step();
    chk("D_pre_Y", 32'(y0), 3);
    chk("D_pre_V", 32'(v0), 1);
    req1 = 4'b1111;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("D_async_V", 32'(v0), 0);
    chk("D_async_gnt", 32'(gnt0), 0);
    chk("D_async_Y", 32'(y0), 0);
    chk("D_async_rrV", 32'(v1), 0);
    chk("D_async_rrY", 32'(y1), 0);
    model_reset();
    req0 = '0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    chk("D_rr_first_Y", 32'(y1), 0);
    chk("D_rr_first_V", 32'(v1), 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      req0 = ($urandom_range(3) == 0) ? '0 : N'($urandom);
      req1 = ($urandom_range(3) == 0) ? '0 : N'($urandom);
      ack0 = 1'($urandom);
      ack1 = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
